bnn_infer_sched: RTL and testbench
==================================

# bnn_infer_sched

Round-robin scheduler that shares one sequential BNN inference core (the rolin-style serial engine, e.g. the Har 12x40x6 instance) among several feature requesters. Grants one requester at a time, latches its feature vector, restarts the core, waits the core's fixed latency, and returns the predicted class tagged with the requester index. Sits between sensor-side feature producers and the shared core.

## Interface

- REQ_CNT, 4, number of requesters; must be >= 2
- FEAT_CNT, 12, features per vector
- FEAT_BITS, 4, bits per feature
- CLASS_CNT, 6, output classes
- LATENCY, 52, cycles from the end of core_restart until core_prediction is valid; must be >= 1

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  REQ_CNT  per-requester request
- req_ready  out  REQ_CNT  one-hot grant; transfer when req_valid[i] & req_ready[i]
- req_features  in  REQ_CNT*FEAT_CNT*FEAT_BITS  requester i occupies slice [i*FEAT_CNT*FEAT_BITS +: FEAT_CNT*FEAT_BITS]
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  $clog2(REQ_CNT)  index of the requester the result belongs to
- resp_class  out  $clog2(CLASS_CNT)  predicted class
- busy  out  1  high in every state except IDLE
- core_restart  out  1  synchronous restart pulse to the core's sequencing counter
- core_features  out  FEAT_CNT*FEAT_BITS  registered feature vector driven to the core
- core_prediction  in  $clog2(CLASS_CNT)  core output, sampled only at end of RUN

## Operation

- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE: round-robin arbiter scans from pointer rr_ptr upward (wrapping at REQ_CNT-1 to 0); the first i with req_valid[i] gets req_ready[i]=1 (combinational, one-hot, zero if no request). On transfer: latch req_features slice into core_features register, latch i into resp_id register, rr_ptr <= (i+1) mod REQ_CNT, go to LOAD.
- req_ready is all-zero outside IDLE; requests are held, never dropped.
- LOAD: core_restart=1 for exactly one cycle; cycle counter cleared; go to RUN.
- RUN: counter increments 0..LATENCY-1; at count LATENCY-1 capture core_prediction into resp_class register, go to RESP.
- RESP: resp_valid=1; resp_id/resp_class stable until resp_ready; on resp_valid & resp_ready go to IDLE.
- core_features holds the granted vector unchanged from LOAD through RESP.
- Counter width $clog2(LATENCY+1); no wrap is reachable.
- Requester deasserting req_valid before grant: legal, simply not granted.

## Timing

- Reset (rst low, async): state=IDLE, rr_ptr=0, core_features=0, resp_id=0, resp_class=0, resp_valid=0, core_restart=0, busy=0, counter=0. req_ready follows combinationally from req_valid with rr_ptr=0.
- Handshake in IDLE at cycle T: LOAD at T+1 (core_restart high), RUN T+2..T+1+LATENCY, resp_valid first high at T+2+LATENCY.
- With resp_ready held high: result accepted at T+2+LATENCY, IDLE at T+3+LATENCY; next grant possible that cycle; minimum grant-to-grant period LATENCY+3.
- resp_ready low: FSM stalls in RESP indefinitely; outputs stable.
- Reset asserted mid-LOAD/RUN/RESP: in-flight result discarded, all registers to reset values immediately; core_restart deasserts asynchronously.

## Structure

- Shared package bnn_sched_pkg: state enum (IDLE, LOAD, RUN, RESP) and width helper localparams (FEAT_W = FEAT_CNT*FEAT_BITS).
- One sub-module natural: rr_arbiter (REQ_CNT requests, pointer input, one-hot grant and encoded index outputs, purely combinational).
- The core (rolin_seq-style instance) is instantiated by the parent, not inside this block.

## Test plan

- Single request: req_valid=4'b0100, features=48'hABC..., LATENCY=52 -> req_ready=4'b0100 at T, core_restart high at T+1 only, resp_valid at T+54 with resp_id=2, resp_class=core value sampled at T+53.
- Fairness: all four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; grants spaced exactly 55 cycles.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp_valid, resp_id, resp_class stable, req_ready=0 throughout, core_features unchanged.
- Pointer wrap: after granting 3 with only req 1 and 3 valid -> next grant is 1, rr_ptr becomes 2.
- Reset mid-RUN: drop rst at RUN count 20 -> busy=0, resp_valid=0 asynchronously; after release, no stale response, rr_ptr=0.
- Idle: req_valid=0 for 100 cycles -> busy=0, core_restart=0, resp_valid=0 throughout.

Source files
------------

// File: rtl/bnn_sched_pkg.sv
// Shared types and default sizing for the BNN inference scheduler.
// The defaults describe the Har 12x40x6 serial core instance.
package bnn_sched_pkg;

  localparam int DEF_REQ_CNT   = 4;
  localparam int DEF_FEAT_CNT  = 12;
  localparam int DEF_FEAT_BITS = 4;
  localparam int DEF_CLASS_CNT = 6;
  localparam int DEF_LATENCY   = 52;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } sched_state_e;

  // Width of one packed feature vector.
  function automatic int feat_w(input int feat_cnt, input int feat_bits);
    return feat_cnt * feat_bits;
  endfunction

endpackage

// File: rtl/bnn_infer_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from i_ptr, wrapping,
// and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int c;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(i_ptr) + k;
      if (c >= N) c = c - N;
      if (!o_any && i_req[IDX_W'(c)]) begin
        o_any               = 1'b1;
        o_grant[IDX_W'(c)]  = 1'b1;
        o_idx               = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/bnn_infer_sched.sv
// Shares one serial BNN inference core among several requesters: grants one
// at a time round-robin, restarts the core, waits its latency, returns the class.
module bnn_infer_sched
  import bnn_sched_pkg::*;
#(
  parameter int REQ_CNT   = DEF_REQ_CNT,
  parameter int FEAT_CNT  = DEF_FEAT_CNT,
  parameter int FEAT_BITS = DEF_FEAT_BITS,
  parameter int CLASS_CNT = DEF_CLASS_CNT,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQ_CNT-1:0]                    req_valid,
  output logic [REQ_CNT-1:0]                    req_ready,
  input  logic [REQ_CNT*FEAT_CNT*FEAT_BITS-1:0] req_features,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [$clog2(REQ_CNT)-1:0]            resp_id,
  output logic [$clog2(CLASS_CNT)-1:0]          resp_class,
  output logic                                  busy,
  output logic                                  core_restart,
  output logic [FEAT_CNT*FEAT_BITS-1:0]         core_features,
  input  logic [$clog2(CLASS_CNT)-1:0]          core_prediction
);

  localparam int VEC_W = feat_w(FEAT_CNT, FEAT_BITS);
  localparam int ID_W  = $clog2(REQ_CNT);
  localparam int CLS_W = $clog2(CLASS_CNT);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(REQ_CNT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  sched_state_e     r_state, w_next;
  logic [ID_W-1:0]  r_rr_ptr, r_resp_id, w_grant_idx;
  logic [CLS_W-1:0] r_resp_class;
  logic [CNT_W-1:0] r_cnt;
  logic [VEC_W-1:0] r_core_features, w_sel_feat;
  logic [REQ_CNT-1:0] w_grant;
  logic             w_grant_any, w_take;

  rr_arbiter #(.N(REQ_CNT), .IDX_W(ID_W)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  assign w_take = (r_state == IDLE) && w_grant_any;

  // The grant is one-hot, so at most one slice is selected.
  always_comb begin
    w_sel_feat = '0;
    for (int i = 0; i < REQ_CNT; i++)
      if (w_grant[i]) w_sel_feat = req_features[i*VEC_W +: VEC_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_any) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (r_cnt == LAST_CNT) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    resp_valid   = 1'b0;
    busy         = 1'b1;
    core_restart = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        busy      = 1'b0;
      end
      LOAD:    core_restart = 1'b1;
      RESP:    resp_valid   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr        <= '0;
      r_core_features <= '0;
      r_resp_id       <= '0;
      r_resp_class    <= '0;
      r_cnt           <= '0;
    end else begin
      if (w_take) begin
        r_core_features <= w_sel_feat;
        r_resp_id       <= w_grant_idx;
        r_rr_ptr        <= (w_grant_idx == LAST_ID) ? '0 : w_grant_idx + ID_W'(1);
      end
      if (r_state == LOAD) begin
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        // The core output is only meaningful on the last RUN cycle.
        if (r_cnt == LAST_CNT) r_resp_class <= core_prediction;
        else                   r_cnt        <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign resp_id       = r_resp_id;
  assign resp_class    = r_resp_class;
  assign core_features = r_core_features;

endmodule

// File: tb/tb_bnn_infer_sched.sv
// Scoreboard bench for bnn_infer_sched: a cycle-level reference model predicts
// grants and results, a separate monitor checks every response the DUT presents.
module tb_bnn_infer_sched;

  localparam int REQ_CNT   = 4;
  localparam int FEAT_CNT  = 12;
  localparam int FEAT_BITS = 4;
  localparam int CLASS_CNT = 6;
  localparam int LATENCY   = 52;
  localparam int FEAT_W    = FEAT_CNT * FEAT_BITS;
  localparam int ID_W      = $clog2(REQ_CNT);
  localparam int CLS_W     = $clog2(CLASS_CNT);

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [REQ_CNT-1:0]          req_valid = '0;
  logic [REQ_CNT-1:0]          req_ready;
  logic [REQ_CNT*FEAT_W-1:0]   req_features = '0;
  logic                        resp_valid;
  logic                        resp_ready = 1'b1;
  logic [ID_W-1:0]             resp_id;
  logic [CLS_W-1:0]            resp_class;
  logic                        busy;
  logic                        core_restart;
  logic [FEAT_W-1:0]           core_features;
  logic [CLS_W-1:0]            core_prediction = '0;

  bnn_infer_sched #(
    .REQ_CNT(REQ_CNT), .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS),
    .CLASS_CNT(CLASS_CNT), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_features(req_features),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_class(resp_class),
    .busy(busy), .core_restart(core_restart),
    .core_features(core_features), .core_prediction(core_prediction)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Stand-in core: its answer depends on the vector it is fed and on time,
  // so a wrong vector or a wrong sampling cycle both show up as a wrong class.
  function automatic int fake_core(input logic [FEAT_W-1:0] f, input int k);
    int s = 0;
    for (int i = 0; i < FEAT_CNT; i++) s += int'(f[i*FEAT_BITS +: FEAT_BITS]);
    return (s + 3 * k) % CLASS_CNT;
  endfunction

  function automatic int pick(input logic [REQ_CNT-1:0] v, input int ptr);
    for (int k = 0; k < REQ_CNT; k++) begin
      int c = (ptr + k) % REQ_CNT;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  typedef struct { int id; int cls; } exp_t;
  exp_t sb[$];

  // Reference model state: whether a job is in flight and when it was granted.
  bit                run_mon = 1'b0;
  int                ncyc = 0;
  bit                m_idle = 1'b1;
  int                m_ptr = 0;
  int                m_grant_k = 0;
  logic [FEAT_W-1:0] m_feat = '0;
  bit                granted [REQ_CNT];
  int                grant_log[$];
  int                grant_k_log[$];

  always @(negedge clk) begin
    int g;
    bit exp_valid;
    logic [REQ_CNT-1:0] er;
    if (run_mon) begin
      g  = m_idle ? pick(req_valid, m_ptr) : -1;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      exp_valid = !m_idle && (ncyc >= m_grant_k + 2 + LATENCY);
      check("req_ready", req_ready, er);
      check("busy", busy, !m_idle);
      check("core_restart", core_restart, !m_idle && (ncyc == m_grant_k + 1));
      check("resp_valid", resp_valid, exp_valid);
      if (!m_idle && ncyc > m_grant_k) check("core_features", core_features, m_feat);
      if (g >= 0) begin
        m_feat    = req_features[g*FEAT_W +: FEAT_W];
        m_grant_k = ncyc;
        m_ptr     = (g + 1) % REQ_CNT;
        m_idle    = 1'b0;
        sb.push_back('{id: g, cls: fake_core(m_feat, ncyc + 1 + LATENCY)});
        granted[g] = 1'b1;
        grant_log.push_back(g);
        grant_k_log.push_back(ncyc);
      end else if (exp_valid && resp_ready) begin
        m_idle = 1'b1;
      end
      core_prediction = CLS_W'(fake_core(core_features, ncyc));
      ncyc++;
    end
  end

  // Response monitor: pops an expectation when a result first appears and
  // holds it against the outputs until the consumer accepts.
  bit   r_have = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (run_mon && resp_valid) begin
      if (!r_have) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", resp_valid, 1'b0);
        end else begin
          cur    = sb.pop_front();
          r_have = 1'b1;
          check("resp_id", resp_id, cur.id);
          check("resp_class", resp_class, cur.cls);
        end
      end else begin
        check("resp_id_hold", resp_id, cur.id);
        check("resp_class_hold", resp_class, cur.cls);
      end
      if (resp_ready) r_have = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_feat(input int i, input logic [FEAT_W-1:0] v);
    req_features[i*FEAT_W +: FEAT_W] = v;
  endtask

  task automatic clear_granted();
    for (int i = 0; i < REQ_CNT; i++) granted[i] = 1'b0;
  endtask

  task automatic drop_granted();
    for (int i = 0; i < REQ_CNT; i++)
      if (granted[i]) begin
        req_valid[i] = 1'b0;
        granted[i]   = 1'b0;
      end
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (grant_log.size() < target && n < budget) begin
      step(1);
      n++;
    end
    check("grant_timeout", grant_log.size() >= target, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!m_idle && n < budget) begin
      step(1);
      n++;
    end
    check("idle_timeout", m_idle, 1'b1);
  endtask

  initial begin
    int base;
    int n;
    clear_granted();

    // Reset state, including the combinational grant with the pointer at 0.
    step(3);
    req_valid = 4'b0110;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_core_restart", core_restart, 1'b0);
    check("rst_core_features", core_features, '0);
    check("rst_resp_id", resp_id, '0);
    check("rst_resp_class", resp_class, '0);
    check("rst_req_ready", req_ready, 4'b0010);
    req_valid = '0;
    step(1);
    rst     = 1'b1;
    run_mon = 1'b1;

    // Idle: nothing may move.
    step(100);

    // Fairness with every requester asserting.
    for (int i = 0; i < REQ_CNT; i++) set_feat(i, FEAT_W'({$urandom(), $urandom()}));
    base = grant_log.size();
    req_valid = 4'b1111;
    wait_grants(base + 5, 6 * (LATENCY + 3));
    req_valid = '0;
    wait_idle(2 * (LATENCY + 3));
    for (int i = 0; i < 5; i++) check("fair_order", grant_log[base + i], i % REQ_CNT);
    for (int i = 1; i < 5; i++)
      check("fair_spacing", grant_k_log[base + i] - grant_k_log[base + i - 1], LATENCY + 3);

    // Single request from requester 2.
    clear_granted();
    set_feat(2, 48'hABC123456789);
    base = grant_log.size();
    req_valid = 4'b0100;
    wait_grants(base + 1, 20);
    drop_granted();
    wait_idle(2 * (LATENCY + 3));
    check("single_id", grant_log[base], 2);

    // Backpressure: hold the result for 20 cycles while requester 1 waits.
    clear_granted();
    set_feat(0, FEAT_W'({$urandom(), $urandom()}));
    set_feat(1, FEAT_W'({$urandom(), $urandom()}));
    base = grant_log.size();
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    wait_grants(base + 1, 20);
    req_valid[0] = 1'b0;
    granted[0]   = 1'b0;
    n = 0;
    while (!resp_valid && n < 2 * LATENCY) begin
      step(1);
      n++;
    end
    step(20);
    resp_ready = 1'b1;
    wait_grants(base + 2, 2 * (LATENCY + 3));
    drop_granted();
    wait_idle(2 * (LATENCY + 3));
    check("bp_order0", grant_log[base], 0);
    check("bp_order1", grant_log[base + 1], 1);

    // Pointer wrap: from pointer 2 with requests 1 and 3, then all four.
    clear_granted();
    base = grant_log.size();
    req_valid = 4'b1010;
    wait_grants(base + 1, 20);
    req_valid[3] = 1'b0;
    wait_grants(base + 2, 2 * (LATENCY + 3));
    req_valid = 4'b1111;
    wait_grants(base + 3, 2 * (LATENCY + 3));
    req_valid = '0;
    check("wrap_first", grant_log[base], 3);
    check("wrap_second", grant_log[base + 1], 1);
    check("wrap_ptr", grant_log[base + 2], 2);

    // Asynchronous reset while the core counter sits at 20.
    step(21);
    run_mon = 1'b0;
    rst     = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_resp_valid", resp_valid, 1'b0);
    check("arst_core_restart", core_restart, 1'b0);
    check("arst_core_features", core_features, '0);
    sb.delete();
    m_idle = 1'b1;
    m_ptr  = 0;
    r_have = 1'b0;
    clear_granted();
    step(3);
    rst     = 1'b1;
    run_mon = 1'b1;
    step(80);
    base = grant_log.size();
    req_valid = 4'b1111;
    wait_grants(base + 1, 20);
    req_valid = '0;
    check("post_rst_ptr", grant_log[base], 0);
    wait_idle(2 * (LATENCY + 3));

    // Randomized traffic with random backpressure and occasional withdrawals.
    clear_granted();
    for (int c = 0; c < 3000; c++) begin
      drop_granted();
      for (int i = 0; i < REQ_CNT; i++) begin
        if (!req_valid[i] && $urandom_range(7) == 0) begin
          set_feat(i, FEAT_W'({$urandom(), $urandom()}));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(3) != 0);
      step(1);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    wait_idle(3 * (LATENCY + 3));
    step(2);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
